// File: rtl/run_ctrl_pkg.sv
// ============================================================================
// run_ctrl_pkg : shared types and sizing helpers for the program-run controller
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

package run_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    INIT = 3'd1,
    RUN  = 3'd2,
    NEXT = 3'd3,
    FIN  = 3'd4
  } run_state_t;

  localparam int DEF_NPROG = 3;
  localparam int SEL_W     = ($clog2(DEF_NPROG) < 1) ? 1 : $clog2(DEF_NPROG);

  // Program-select width for an arbitrary program count; never narrower than 1.
  function automatic int sel_width(input int n);
    return ($clog2(n) < 1) ? 1 : $clog2(n);
  endfunction

endpackage

`default_nettype wire

// File: rtl/run_ctrl_sat.sv
// ============================================================================
// sat_counter : W-bit up-counter with sync clear, enable and sticky overflow
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_clr,
  input  logic         i_en,
  output logic [W-1:0] o_cnt,
  output logic         o_ovf
);

  localparam logic [W-1:0] C_MAX = '1;

  logic [W-1:0] r_cnt;
  logic         r_ovf;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else if (i_clr) begin
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else if (i_en) begin
      if (r_cnt != C_MAX) r_cnt <= r_cnt + 1'b1;
      // Flag rises on the increment that lands on the ceiling.
      if (r_cnt >= C_MAX - 1'b1) r_ovf <= 1'b1;
    end
  end

  assign o_cnt = r_cnt;
  assign o_ovf = r_ovf;

endmodule

`default_nettype wire

// File: rtl/run_ctrl.sv
// ============================================================================
// run_ctrl : sequences NPROG programs through the core, timing each run.
//            Optional macro RUN_CTRL_AUTOCHAIN_EN chains programs after one go.
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module run_ctrl
  import run_ctrl_pkg::*;
#(
  parameter int PW    = 10,
  parameter int NPROG = 3,
  parameter int CW    = 16
) (
  input  logic                            CLK,
  input  logic                            start_n,
  input  logic                            go,
  input  logic [NPROG*PW-1:0]             prog_base,
  input  logic                            core_halt,
  output logic                            core_init,
  output logic [PW-1:0]                   pc_base,
  output logic [sel_width(NPROG)-1:0]     prog_sel,
  output logic                            running,
  output logic [NPROG-1:0]                prog_done,
  output logic [NPROG-1:0]                prog_ovf,
  output logic [NPROG*CW-1:0]             cycle_ct,
  output logic                            halt
);

  localparam int             SW       = sel_width(NPROG);
  localparam logic [SW-1:0]  LAST_SEL = SW'(NPROG - 1);

  run_state_t       r_state, w_state_nxt;
  logic [SW-1:0]    r_sel, w_sel_nxt;
  logic             r_core_init, r_running, r_halt;
  logic [NPROG-1:0] r_done;
  logic [NPROG-1:0] w_sel_hot, w_clr, w_en;

  always_comb begin
    w_state_nxt = r_state;
    w_sel_nxt   = r_sel;
    case (r_state)
      IDLE: if (go) w_state_nxt = (&r_done) ? FIN : INIT;
      INIT: w_state_nxt = RUN;
      RUN:  if (core_halt) w_state_nxt = NEXT;
      NEXT: begin
        if (r_sel == LAST_SEL) begin
          w_state_nxt = FIN;
        end else begin
          w_sel_nxt = r_sel + 1'b1;
`ifdef RUN_CTRL_AUTOCHAIN_EN
          w_state_nxt = INIT;
`else
          w_state_nxt = IDLE;
`endif
        end
      end
      FIN:     w_state_nxt = FIN;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they leave the flops glitch-free.
  always_ff @(posedge CLK) begin
    if (!start_n) begin
      r_state     <= IDLE;
      r_sel       <= '0;
      r_core_init <= 1'b0;
      r_running   <= 1'b0;
      r_halt      <= 1'b0;
      r_done      <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_sel       <= w_sel_nxt;
      r_core_init <= (w_state_nxt == INIT);
      r_running   <= (w_state_nxt == RUN);
      r_halt      <= (w_state_nxt == FIN);
      if (r_state == NEXT) r_done <= r_done | w_sel_hot;
    end
  end

  assign w_clr = w_sel_hot & {NPROG{r_state == INIT}};
  assign w_en  = w_sel_hot & {NPROG{(r_state == RUN) && !core_halt}};

  generate
    for (genvar i = 0; i < NPROG; i++) begin : g_prog
      assign w_sel_hot[i] = (r_sel == SW'(i));

      sat_counter #(.W(CW)) u_cnt (
        .clk   (CLK),
        .rst_n (start_n),
        .i_clr (w_clr[i]),
        .i_en  (w_en[i]),
        .o_cnt (cycle_ct[i*CW +: CW]),
        .o_ovf (prog_ovf[i])
      );
    end
  endgenerate

  always_comb begin
    pc_base = '0;
    for (int i = 0; i < NPROG; i++) begin
      if (r_sel == SW'(i)) pc_base = prog_base[i*PW +: PW];
    end
  end

  assign core_init = r_core_init;
  assign running   = r_running;
  assign halt      = r_halt;
  assign prog_sel  = r_sel;
  assign prog_done = r_done;

endmodule

`default_nettype wire

// File: tb/tb_run_ctrl.sv
// ============================================================================
// tb_run_ctrl : randomized self-checking bench for run_ctrl (NPROG=3, CW=4)
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_run_ctrl;

  localparam int PW    = 10;
  localparam int NPROG = 3;
  localparam int CW    = 4;
  localparam int SW    = 2;
  localparam int MAXC  = (1 << CW) - 1;
`ifdef RUN_CTRL_AUTOCHAIN_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic                  CLK = 1'b0;
  logic                  start_n, go, core_halt;
  logic [NPROG*PW-1:0]   prog_base;
  logic                  core_init, running, halt;
  logic [PW-1:0]         pc_base;
  logic [SW-1:0]         prog_sel;
  logic [NPROG-1:0]      prog_done, prog_ovf;
  logic [NPROG*CW-1:0]   cycle_ct;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: per-program results in plain integers.
  int ref_ct   [NPROG];
  bit ref_done [NPROG];
  bit ref_ovf  [NPROG];
  int ref_sel;
  bit ref_halt;

  run_ctrl #(.PW(PW), .NPROG(NPROG), .CW(CW)) dut (
    .CLK       (CLK),
    .start_n   (start_n),
    .go        (go),
    .prog_base (prog_base),
    .core_halt (core_halt),
    .core_init (core_init),
    .pc_base   (pc_base),
    .prog_sel  (prog_sel),
    .running   (running),
    .prog_done (prog_done),
    .prog_ovf  (prog_ovf),
    .cycle_ct  (cycle_ct),
    .halt      (halt)
  );

  always #5 CLK = ~CLK;

  task automatic step;
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset;
    start_n = 1'b0; go = 1'b0; core_halt = 1'b0;
    step; step;
    start_n = 1'b1;
    for (int i = 0; i < NPROG; i++) begin
      ref_ct[i] = 0; ref_done[i] = 1'b0; ref_ovf[i] = 1'b0;
    end
    ref_sel = 0; ref_halt = 1'b0;
  endtask

  // One program: optional go, INIT, n counted RUN cycles, halt cycle, NEXT.
  task automatic run_prog(input int n, input bit do_go, input bit noise);
    int s;
    logic [PW-1:0] base;
    logic [NPROG-1:0] e_done, e_ovf;
    s = ref_sel;
    base = prog_base[s*PW +: PW];
    if (do_go) begin go = 1'b1; step; go = 1'b0; end
    n_cmp++;
    if (core_init !== 1'b1 || pc_base !== base || prog_sel !== SW'(s) || running !== 1'b0) begin
      n_err++;
      $display("FAIL init p%0d: core_init=%b pc_base=%h sel=%0d running=%b, want 1 %h %0d 0",
               s, core_init, pc_base, prog_sel, running, base, s);
    end
    step;
    n_cmp++;
    if (core_init !== 1'b0 || running !== 1'b1) begin
      n_err++;
      $display("FAIL run_entry p%0d: core_init=%b running=%b, want 0 1", s, core_init, running);
    end
    for (int k = 0; k < n; k++) begin
      if (noise) go = 1'($urandom_range(0, 1));
      step;
    end
    go = 1'b0; core_halt = 1'b1;
    step;
    core_halt = 1'b0;
    n_cmp++;
    if (running !== 1'b0 || prog_done[s] !== 1'b0) begin
      n_err++;
      $display("FAIL next p%0d: running=%b done=%b, want 0 0", s, running, prog_done[s]);
    end
    ref_ct[s]   = (n > MAXC) ? MAXC : n;
    ref_ovf[s]  = (n >= MAXC);
    ref_done[s] = 1'b1;
    if (s == NPROG - 1) ref_halt = 1'b1;
    else ref_sel = s + 1;
    step;
    for (int i = 0; i < NPROG; i++) begin
      e_done[i] = ref_done[i];
      e_ovf[i]  = ref_ovf[i];
    end
    n_cmp++;
    if (prog_done !== e_done || prog_ovf !== e_ovf || prog_sel !== SW'(ref_sel) || halt !== ref_halt) begin
      n_err++;
      $display("FAIL flags p%0d: done=%b ovf=%b sel=%0d halt=%b, want %b %b %0d %b",
               s, prog_done, prog_ovf, prog_sel, halt, e_done, e_ovf, ref_sel, ref_halt);
    end
    for (int i = 0; i < NPROG; i++) begin
      n_cmp++;
      if (cycle_ct[i*CW +: CW] !== CW'(ref_ct[i])) begin
        n_err++;
        $display("FAIL cycle_ct[%0d] after p%0d: got %0d want %0d", i, s, cycle_ct[i*CW +: CW], ref_ct[i]);
      end
    end
    n_cmp++;
    if (core_init !== (AUTO && !ref_halt) || running !== 1'b0) begin
      n_err++;
      $display("FAIL post_next p%0d: core_init=%b running=%b, want %b 0",
               s, core_init, running, AUTO && !ref_halt);
    end
  endtask

  task automatic run_all(input int n0, input int n1, input int n2, input bit noise);
    int n[NPROG];
    n[0] = n0; n[1] = n1; n[2] = n2;
    for (int i = 0; i < NPROG; i++) run_prog(n[i], AUTO ? (i == 0) : 1'b1, noise);
  endtask

  task automatic test_reset;
    do_reset;
    n_cmp++;
    if (halt !== 1'b0 || running !== 1'b0 || core_init !== 1'b0 || prog_done !== '0 ||
        prog_ovf !== '0 || cycle_ct !== '0 || prog_sel !== '0) begin
      n_err++;
      $display("FAIL reset: halt=%b run=%b init=%b done=%b ovf=%b ct=%h sel=%0d, want all zero",
               halt, running, core_init, prog_done, prog_ovf, cycle_ct, prog_sel);
    end
  endtask

  task automatic test_directed;
    logic [NPROG*CW-1:0] exp_ct;
    prog_base = {10'h200, 10'h100, 10'h000};
    do_reset;
    run_all(5, 7, 3, 1'b0);
    exp_ct = {4'd3, 4'd7, 4'd5};
    n_cmp++;
    if (cycle_ct !== exp_ct || prog_done !== 3'b111 || halt !== 1'b1) begin
      n_err++;
      $display("FAIL directed: ct=%h done=%b halt=%b, want %h 111 1", cycle_ct, prog_done, halt, exp_ct);
    end
  endtask

  task automatic test_fin_go;
    logic [NPROG*CW-1:0] held;
    held = cycle_ct;
    go = 1'b1; step; go = 1'b0; step; step;
    n_cmp++;
    if (halt !== 1'b1 || core_init !== 1'b0 || running !== 1'b0 ||
        prog_sel !== SW'(NPROG - 1) || cycle_ct !== held) begin
      n_err++;
      $display("FAIL fin_go: halt=%b init=%b run=%b sel=%0d ct=%h, want 1 0 0 %0d %h",
               halt, core_init, running, prog_sel, cycle_ct, NPROG - 1, held);
    end
  endtask

  task automatic test_saturation;
    do_reset;
    run_all(20, 15, 14, 1'b0);
    n_cmp++;
    if (prog_ovf !== 3'b011 || cycle_ct !== {4'd14, 4'd15, 4'd15}) begin
      n_err++;
      $display("FAIL saturation: ovf=%b ct=%h, want 011 eff", prog_ovf, cycle_ct);
    end
  endtask

  task automatic test_reset_mid_run;
    do_reset;
    run_prog(4, 1'b1, 1'b0);
    if (!AUTO) begin go = 1'b1; step; go = 1'b0; end
    step;
    repeat (4) step;
    start_n = 1'b0; step; start_n = 1'b1;
    n_cmp++;
    if (running !== 1'b0 || prog_sel !== '0 || prog_done !== '0 || prog_ovf !== '0 ||
        cycle_ct !== '0 || halt !== 1'b0 || core_init !== 1'b0) begin
      n_err++;
      $display("FAIL mid_run_reset: run=%b sel=%0d done=%b ovf=%b ct=%h halt=%b init=%b, want all zero",
               running, prog_sel, prog_done, prog_ovf, cycle_ct, halt, core_init);
    end
    for (int i = 0; i < NPROG; i++) begin
      ref_ct[i] = 0; ref_done[i] = 1'b0; ref_ovf[i] = 1'b0;
    end
    ref_sel = 0; ref_halt = 1'b0;
    run_all(int'($urandom_range(0, 18)), int'($urandom_range(0, 18)), int'($urandom_range(0, 18)), 1'b1);
  endtask

  task automatic test_random;
    for (int it = 0; it < 6; it++) begin
      prog_base = NPROG*PW'({$urandom, $urandom});
      do_reset;
      run_all(int'($urandom_range(0, 18)), int'($urandom_range(0, 18)), int'($urandom_range(0, 18)), 1'b1);
    end
  endtask

  initial begin
    start_n = 1'b0; go = 1'b0; core_halt = 1'b0;
    prog_base = '0;
    test_reset;
    test_directed;
    test_fin_go;
    test_saturation;
    test_reset_mid_run;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
